// File: rtl/sdram_arb_pkg.sv
// Shared definitions for the two-master SDRAM arbiter.
//   mst_e          : master identifier stored in the grant lock and the read tag FIFO
//   M1_BYTEENABLE  : byteenable presented on behalf of the SD-card master
package sdram_arb_pkg;

  typedef enum logic {
    MST_CPU = 1'b0,
    MST_SD  = 1'b1
  } mst_e;

  localparam logic [3:0] M1_BYTEENABLE = 4'b1111;

endpackage

// File: rtl/sdram_arb_tagfifo.sv
// Read-response tag FIFO: remembers which master issued each outstanding read.
//   clk, rst   : clock, asynchronous active-high reset (empties the FIFO)
//   push       : store push_data (ignored when full)
//   push_data  : master ID of the accepted read
//   pop        : discard head (ignored when empty)
//   full/empty : occupancy flags, registered-state only (a pop never frees a slot in its own cycle)
//   head       : master ID of the oldest outstanding read
module sdram_arb_tagfifo #(
  parameter int unsigned TAG_DEPTH = 8,
  parameter int unsigned TAG_AW    = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic push,
  input  logic push_data,
  input  logic pop,
  output logic full,
  output logic empty,
  output logic head
);

  logic              mem [TAG_DEPTH];
  logic [TAG_AW-1:0] wr_ptr;
  logic [TAG_AW-1:0] rd_ptr;
  logic [TAG_AW:0]   count;
  logic              do_push;
  logic              do_pop;

  assign full    = (count == (TAG_AW+1)'(TAG_DEPTH));
  assign empty   = (count == '0);
  assign head    = mem[rd_ptr];
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  // Pointers are TAG_AW wide so they wrap modulo TAG_DEPTH on their own.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/sdram_arbiter.sv
// Round-robin arbiter sharing one SDRAM Avalon-MM slave between the CPU path (m0)
// and the SD-card driver (m1), clk_sys domain.
//   clk_sys, rst         : clock, asynchronous active-high reset
//   ao486_rst            : CPU held in reset; m0 is not granted new commands
//   m0_* / m1_*          : Avalon-MM master-side ports (m1 byteenable fixed all-ones)
//   sdram_*              : Avalon-MM slave-side ports, driven by the granted master
//   err_orphan           : sticky, readdatavalid arrived with no outstanding read
// A stalled command keeps its grant until accepted; read data is routed back
// in issue order using a tag FIFO of master IDs.
module sdram_arbiter
  import sdram_arb_pkg::*;
#(
  parameter int unsigned OADDR     = 25,
  parameter int unsigned TAG_DEPTH = 8,
  parameter int unsigned TAG_AW    = 3
) (
  input  logic             clk_sys,
  input  logic             rst,
  input  logic             ao486_rst,

  input  logic [31:0]      m0_address,
  input  logic [3:0]       m0_byteenable,
  input  logic [31:0]      m0_writedata,
  input  logic             m0_read,
  input  logic             m0_write,
  output logic             m0_waitrequest,
  output logic [31:0]      m0_readdata,
  output logic             m0_readdatavalid,

  input  logic [31:0]      m1_address,
  input  logic [31:0]      m1_writedata,
  input  logic             m1_read,
  input  logic             m1_write,
  output logic             m1_waitrequest,
  output logic [31:0]      m1_readdata,
  output logic             m1_readdatavalid,

  output logic [OADDR-1:0] sdram_address,
  output logic [3:0]       sdram_byteenable,
  output logic             sdram_read,
  output logic             sdram_write,
  output logic [31:0]      sdram_writedata,
  input  logic             sdram_waitrequest,
  input  logic [31:0]      sdram_readdata,
  input  logic             sdram_readdatavalid,

  output logic             err_orphan
);

  logic lock;
  mst_e owner;
  mst_e last_owner;

  logic grant_valid;
  mst_e grant;
  logic req0, req1, elig0, elig1;
  logic cmd, accept, stall;

  logic tag_full, tag_empty, tag_head;
  logic tag_push, tag_pop;

  logic unused_bits;
  assign unused_bits = ^{m0_address[1:0], m0_address[31:OADDR+2],
                         m1_address[1:0], m1_address[31:OADDR+2]};

  assign req0  = (m0_read | m0_write) & ~ao486_rst;
  assign req1  = m1_read | m1_write;
  assign elig0 = req0 & ~(m0_read & tag_full);
  assign elig1 = req1 & ~(m1_read & tag_full);

  always_comb begin
    grant_valid = 1'b0;
    grant       = MST_CPU;
    if (lock) begin
      // Locked owner keeps the bus even if ao486_rst rose meanwhile.
      grant_valid = 1'b1;
      grant       = owner;
    end else if (elig0 && elig1) begin
      grant_valid = 1'b1;
      grant       = (last_owner == MST_CPU) ? MST_SD : MST_CPU;
    end else if (elig0) begin
      grant_valid = 1'b1;
      grant       = MST_CPU;
    end else if (elig1) begin
      grant_valid = 1'b1;
      grant       = MST_SD;
    end
  end

  always_comb begin
    if (grant == MST_SD) begin
      sdram_address    = m1_address[OADDR+1:2];
      sdram_byteenable = M1_BYTEENABLE;
      sdram_writedata  = m1_writedata;
      sdram_read       = grant_valid & m1_read;
      sdram_write      = grant_valid & m1_write;
    end else begin
      sdram_address    = m0_address[OADDR+1:2];
      sdram_byteenable = m0_byteenable;
      sdram_writedata  = m0_writedata;
      sdram_read       = grant_valid & m0_read;
      sdram_write      = grant_valid & m0_write;
    end
  end

  assign cmd    = sdram_read | sdram_write;
  assign accept = cmd & ~sdram_waitrequest;
  assign stall  = cmd & sdram_waitrequest;

  assign m0_waitrequest = ~(grant_valid && (grant == MST_CPU) && !sdram_waitrequest);
  assign m1_waitrequest = ~(grant_valid && (grant == MST_SD)  && !sdram_waitrequest);

  always_ff @(posedge clk_sys or posedge rst) begin
    if (rst) begin
      lock       <= 1'b0;
      owner      <= MST_CPU;
      last_owner <= MST_SD;
    end else if (accept) begin
      lock       <= 1'b0;
      last_owner <= grant;
    end else if (stall) begin
      lock       <= 1'b1;
      owner      <= grant;
    end
  end

  assign tag_push = accept & sdram_read;
  assign tag_pop  = sdram_readdatavalid;

  sdram_arb_tagfifo #(
    .TAG_DEPTH (TAG_DEPTH),
    .TAG_AW    (TAG_AW)
  ) u_tagfifo (
    .clk       (clk_sys),
    .rst       (rst),
    .push      (tag_push),
    .push_data (grant),
    .pop       (tag_pop),
    .full      (tag_full),
    .empty     (tag_empty),
    .head      (tag_head)
  );

  assign m0_readdata      = sdram_readdata;
  assign m1_readdata      = sdram_readdata;
  assign m0_readdatavalid = sdram_readdatavalid & ~tag_empty & (mst_e'(tag_head) == MST_CPU);
  assign m1_readdatavalid = sdram_readdatavalid & ~tag_empty & (mst_e'(tag_head) == MST_SD);

  always_ff @(posedge clk_sys or posedge rst) begin
    if (rst)                                   err_orphan <= 1'b0;
    else if (sdram_readdatavalid && tag_empty) err_orphan <= 1'b1;
  end

endmodule

// File: tb/tb_sdram_arbiter.sv
module tb_sdram_arbiter;

  logic        clk_sys = 1'b0;
  logic        rst, ao486_rst;
  logic [31:0] m0_address, m0_writedata, m1_address, m1_writedata;
  logic [3:0]  m0_byteenable;
  logic        m0_read, m0_write, m1_read, m1_write;
  logic        m0_waitrequest, m0_readdatavalid, m1_waitrequest, m1_readdatavalid;
  logic [31:0] m0_readdata, m1_readdata;
  logic [24:0] sdram_address;
  logic [3:0]  sdram_byteenable;
  logic        sdram_read, sdram_write, sdram_waitrequest, sdram_readdatavalid;
  logic [31:0] sdram_writedata, sdram_readdata;
  logic        err_orphan;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  always #5 clk_sys = ~clk_sys;

  sdram_arbiter #(.OADDR(25), .TAG_DEPTH(8), .TAG_AW(3)) dut (
    .clk_sys(clk_sys), .rst(rst), .ao486_rst(ao486_rst),
    .m0_address(m0_address), .m0_byteenable(m0_byteenable), .m0_writedata(m0_writedata),
    .m0_read(m0_read), .m0_write(m0_write), .m0_waitrequest(m0_waitrequest),
    .m0_readdata(m0_readdata), .m0_readdatavalid(m0_readdatavalid),
    .m1_address(m1_address), .m1_writedata(m1_writedata),
    .m1_read(m1_read), .m1_write(m1_write), .m1_waitrequest(m1_waitrequest),
    .m1_readdata(m1_readdata), .m1_readdatavalid(m1_readdatavalid),
    .sdram_address(sdram_address), .sdram_byteenable(sdram_byteenable),
    .sdram_read(sdram_read), .sdram_write(sdram_write), .sdram_writedata(sdram_writedata),
    .sdram_waitrequest(sdram_waitrequest), .sdram_readdata(sdram_readdata),
    .sdram_readdatavalid(sdram_readdatavalid), .err_orphan(err_orphan)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge; caller then drives inputs,
  // and checks after settle().
  task automatic next_cycle();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic idle_inputs();
    m0_read = 0; m0_write = 0; m1_read = 0; m1_write = 0;
    sdram_waitrequest = 0; sdram_readdatavalid = 0;
  endtask

  initial begin
    rst = 1; ao486_rst = 0;
    m0_address = '0; m0_writedata = '0; m0_byteenable = 4'h3;
    m1_address = '0; m1_writedata = '0;
    sdram_readdata = '0;
    idle_inputs();
    #3;
    check("rst_sdram_read",  sdram_read, 0);
    check("rst_sdram_write", sdram_write, 0);
    check("rst_m0_rdv",      m0_readdatavalid, 0);
    check("rst_m1_rdv",      m1_readdatavalid, 0);
    check("rst_err_orphan",  err_orphan, 0);
    check("rst_m0_wait",     m0_waitrequest, 1);
    next_cycle();
    rst = 0;

    // Round robin: both write every cycle, m0 wins the first tie.
    m0_address = 32'h100; m0_writedata = 32'hA0;
    m1_address = 32'h200; m1_writedata = 32'hB1;
    for (int i = 0; i < 4; i++) begin
      next_cycle();
      m0_write = 1; m1_write = 1;
      settle();
      check("rr_addr",  sdram_address, (i % 2 == 0) ? 32'h40 : 32'h80);
      check("rr_m0_wr", m0_waitrequest, (i % 2 == 0) ? 0 : 1);
      check("rr_m1_wr", m1_waitrequest, (i % 2 == 0) ? 1 : 0);
      check("rr_be",    sdram_byteenable, (i % 2 == 0) ? 32'h3 : 32'hF);
      check("rr_wdata", sdram_writedata, (i % 2 == 0) ? 32'hA0 : 32'hB1);
    end

    // Lock: m1 read stalls 3 cycles; m0 joins and would win a tie, but lock holds m1.
    next_cycle();
    m0_write = 0; m1_write = 0;
    m1_address = 32'h0800_0010; m1_read = 1; sdram_waitrequest = 1;
    settle();
    check("lk_addr0", sdram_address, 32'h4);
    check("lk_rd0",   sdram_read, 1);
    check("lk_m1w0",  m1_waitrequest, 1);
    for (int i = 0; i < 2; i++) begin
      next_cycle();
      m0_write = 1;
      settle();
      check("lk_addr",  sdram_address, 32'h4);
      check("lk_wr",    sdram_write, 0);
      check("lk_m0w",   m0_waitrequest, 1);
    end
    next_cycle();
    sdram_waitrequest = 0;
    settle();
    check("lk_acc_m1w", m1_waitrequest, 0);
    check("lk_acc_m0w", m0_waitrequest, 1);
    check("lk_acc_addr", sdram_address, 32'h4);
    next_cycle();
    m1_read = 0;
    settle();
    check("lk_after_m0w", m0_waitrequest, 0);
    check("lk_after_wr",  sdram_write, 1);
    check("lk_after_addr", sdram_address, 32'h40);
    next_cycle();
    m0_write = 0; sdram_readdatavalid = 1; sdram_readdata = 32'h1111;
    settle();
    check("lk_rsp_m1v", m1_readdatavalid, 1);
    check("lk_rsp_m0v", m0_readdatavalid, 0);
    check("lk_rsp_dat", m1_readdata, 32'h1111);

    // FIFO full: 8 m0 reads outstanding block the 9th; writes still flow.
    for (int i = 0; i < 8; i++) begin
      next_cycle();
      sdram_readdatavalid = 0;
      m0_read = 1; m0_address = 32'h1000 + 32'(i * 4);
      settle();
      check("ff_m0w", m0_waitrequest, 0);
    end
    next_cycle();
    m0_address = 32'h2000; m1_write = 1; m1_address = 32'h200;
    settle();
    check("ff_blk_m0w", m0_waitrequest, 1);
    check("ff_blk_rd",  sdram_read, 0);
    check("ff_wr_m1w",  m1_waitrequest, 0);
    check("ff_wr_wr",   sdram_write, 1);
    next_cycle();
    m1_write = 0; sdram_readdatavalid = 1; sdram_readdata = 32'hD00D;
    settle();
    check("ff_pop_m0v", m0_readdatavalid, 1);
    check("ff_pop_dat", m0_readdata, 32'hD00D);
    check("ff_pop_m0w", m0_waitrequest, 1);
    next_cycle();
    sdram_readdatavalid = 0;
    settle();
    check("ff_9th_m0w", m0_waitrequest, 0);
    check("ff_9th_addr", sdram_address, 32'h800);
    for (int i = 0; i < 8; i++) begin
      next_cycle();
      m0_read = 0; sdram_readdatavalid = 1;
      settle();
      check("ff_drain_m0v", m0_readdatavalid, 1);
      check("ff_drain_m1v", m1_readdatavalid, 0);
    end

    // Interleaved reads m0, m1, m0 -> responses routed in order.
    next_cycle();
    sdram_readdatavalid = 0; m0_read = 1;
    settle();
    check("il_m0w", m0_waitrequest, 0);
    next_cycle();
    m0_read = 0; m1_read = 1;
    settle();
    check("il_m1w", m1_waitrequest, 0);
    next_cycle();
    m1_read = 0; m0_read = 1;
    settle();
    check("il_m0w2", m0_waitrequest, 0);
    for (int i = 0; i < 3; i++) begin
      next_cycle();
      m0_read = 0; sdram_readdatavalid = 1; sdram_readdata = 32'hD0 + 32'(i);
      settle();
      check("il_m0v", m0_readdatavalid, (i == 1) ? 0 : 1);
      check("il_m1v", m1_readdatavalid, (i == 1) ? 1 : 0);
      check("il_dat", (i == 1) ? m1_readdata : m0_readdata, 32'hD0 + 32'(i));
    end

    // CPU in reset: m0 never granted, m1 gets every slot; orphan response.
    for (int i = 0; i < 3; i++) begin
      next_cycle();
      sdram_readdatavalid = 0; ao486_rst = 1; m0_read = 1; m1_write = 1;
      settle();
      check("ao_m0w", m0_waitrequest, 1);
      check("ao_m1w", m1_waitrequest, 0);
    end
    next_cycle();
    m1_write = 0;
    settle();
    check("ao_idle_m0w", m0_waitrequest, 1);
    check("ao_idle_rd",  sdram_read, 0);
    next_cycle();
    sdram_readdatavalid = 1;
    settle();
    check("orph_m0v", m0_readdatavalid, 0);
    check("orph_m1v", m1_readdatavalid, 0);
    check("orph_pre", err_orphan, 0);
    next_cycle();
    sdram_readdatavalid = 0;
    settle();
    check("orph_set", err_orphan, 1);
    next_cycle();
    next_cycle();
    check("orph_hold", err_orphan, 1);
    rst = 1;
    #1;
    check("orph_clr", err_orphan, 0);
    next_cycle();
    rst = 0;
    idle_inputs();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
